dmem_loader: RTL and testbench



---
 rtl/rv32i_pkg.sv | 18 +
 rtl/byte_packer.sv | 39 +++
 rtl/dmem_loader.sv | 152 +++++++++++++++
 tb/tb_dmem_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared pipeline package: datapath width plus the preload-loader state
// encoding and counter width.
package rv32i_pkg;

  localparam int DPW          = 32;
  localparam int LOADER_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler. Each load drops the byte into the
// lane selected by the 2-bit byte index. On the fourth load, word_full is
// raised and word already carries that fourth byte.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic        word_full,
  output logic [31:0] word
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  // Merge the incoming byte into its lane so a completed word is usable this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    word                          = word_q;
    word[{idx_q, 3'b000} +: 8]    = byte_in;
    word_full                     = load && (idx_q == 2'd3);
  end

  // Byte index and assembly register update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst || clear) begin
      idx_q <= 2'd0;
    end else if (load) begin
      idx_q <= idx_q + 2'd1;
    end
    // NOTE: the assembly register is left unreset; all four lanes are rewritten before word_full.
    if (load) begin
      word_q <= word;
    end
  end

endmodule

// File: rtl/dmem_loader.sv
// Data-memory preload controller: parses a [count_lo, count_hi, data...]
// byte stream and issues one data-cache write per little-endian word.
// Optional trailing XOR checksum byte: define DMEM_LOADER_CHECKSUM_EN.
module dmem_loader
  import rv32i_pkg::*;
#(
  parameter logic [DPW-1:0] BASE_ADDR = '0,
  parameter int             MAX_WORDS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  output logic                    byte_ready,
  output logic                    data_en,
  output logic [DPW-1:0]          input_addr,
  output logic [DPW-1:0]          input_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [LOADER_CNT_W-1:0] word_cnt
);

`ifdef DMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t TAIL_STATE = ST_CHECK;
`else
  localparam loader_state_t TAIL_STATE = ST_DONE;
`endif

  loader_state_t           state_q, state_next;
  logic [7:0]              count_lo_q;
  logic [LOADER_CNT_W-1:0] count_q;
  logic [LOADER_CNT_W-1:0] cnt_in;
  logic [DPW-1:0]          addr_q;
  logic                    xfer;
  logic                    start_go;
  logic                    err_set;
  logic                    pk_load;
  logic                    pk_full;
  logic [31:0]             pk_word;
`ifdef DMEM_LOADER_CHECKSUM_EN
  logic [7:0]              xor_q;
`endif

  assign byte_ready = (state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK});
  assign xfer       = byte_valid && byte_ready;
  assign start_go   = start && (state_q inside {ST_IDLE, ST_DONE});
  assign pk_load    = xfer && (state_q == ST_DATA);
  assign cnt_in     = {byte_data, count_lo_q};

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_go),
    .load      (pk_load),
    .byte_in   (byte_data),
    .word_full (pk_full),
    .word      (pk_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_next;
  end

  // Next-state decode and error detection.
  always_comb begin
    state_next = state_q;
    err_set    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_next = ST_LEN_LO;
      ST_LEN_LO:        if (xfer)  state_next = ST_LEN_HI;
      ST_LEN_HI: begin
        if (xfer) begin
          if (cnt_in == '0) begin
            state_next = TAIL_STATE;
          end else if (32'(cnt_in) > MAX_WORDS) begin
            state_next = ST_DONE;
            err_set    = 1'b1;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA:  if (pk_full) state_next = ST_WRITE;
      ST_WRITE: state_next = ((word_cnt + 16'd1) < count_q) ? ST_DATA : TAIL_STATE;
      ST_CHECK: begin
`ifdef DMEM_LOADER_CHECKSUM_EN
        if (xfer) begin
          state_next = ST_DONE;
          err_set    = (byte_data != xor_q);
        end
`else
        state_next = ST_DONE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered outputs, counters and the running checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_en    <= 1'b0;
      input_addr <= '0;
      input_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_cnt   <= '0;
      count_lo_q <= '0;
      count_q    <= '0;
      addr_q     <= BASE_ADDR;
`ifdef DMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      data_en <= (state_next == ST_WRITE);
      busy    <= !(state_next inside {ST_IDLE, ST_DONE});
      done    <= (state_next == ST_DONE);

      if (start_go) begin
        err      <= 1'b0;
        word_cnt <= '0;
        addr_q   <= BASE_ADDR;
`ifdef DMEM_LOADER_CHECKSUM_EN
        xor_q    <= '0;
`endif
      end
      if (err_set) err <= 1'b1;

      if (xfer && (state_q == ST_LEN_LO)) count_lo_q <= byte_data;
      if (xfer && (state_q == ST_LEN_HI)) count_q    <= cnt_in;
`ifdef DMEM_LOADER_CHECKSUM_EN
      if (pk_load) xor_q <= xor_q ^ byte_data;
`endif

      // Present the completed word; address and data then hold until the next one.
      if (pk_full) begin
        input_data <= pk_word;
        input_addr <= addr_q;
      end
      if (state_q == ST_WRITE) begin
        word_cnt <= word_cnt + 16'd1;
        addr_q   <= addr_q + DPW'(4);
      end
    end
  end

endmodule

// File: tb/tb_dmem_loader.sv
// Self-checking bench for dmem_loader: directed sessions plus randomized
// streams compared against a stream-parsing reference model.
module tb_dmem_loader;
  import rv32i_pkg::*;

  localparam logic [DPW-1:0] BASE = '0;
  localparam int             MAXW = 256;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic                    clk = 1'b0;
  logic                    rst, start, byte_valid;
  logic [7:0]              byte_data;
  logic                    byte_ready, data_en, busy, done, err;
  logic [DPW-1:0]          input_addr, input_data;
  logic [LOADER_CNT_W-1:0] word_cnt;

  int      total = 0;
  int      bad   = 0;
  byte_q_t stream;
  wr_t     wr_q[$];
  wr_t     exp_q[$];
  bit      exp_err;
  int      ready_in_write;

  always #5 clk = ~clk;

  dmem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .data_en    (data_en),
    .input_addr (input_addr),
    .input_data (input_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_cnt   (word_cnt)
  );

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (data_en) begin
      wr_q.push_back(wr_t'{addr: input_addr, data: input_data});
      if (byte_ready) ready_in_write++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: parse the stream into the writes and error flag it implies.
  task automatic model_stream(input byte_q_t s);
    int          cnt;
    logic [7:0]  x;
    logic [31:0] w;
    exp_q.delete();
    exp_err = 1'b0;
    x       = 8'h00;
    cnt     = int'({s[1], s[0]});
    if (cnt > MAXW) begin
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < cnt; k++) begin
      w = {s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]};
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      exp_q.push_back(wr_t'{addr: BASE + 32'(4*k), data: w});
    end
`ifdef DMEM_LOADER_CHECKSUM_EN
    if (s[2+4*cnt] !== x) exp_err = 1'b1;
`endif
  endtask

  // Appends the checksum byte when the feature is built in (corrupted if bad_sum).
  task automatic add_tail(input bit bad_sum);
`ifdef DMEM_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int k = 2; k < stream.size(); k++) x = x ^ stream[k];
    stream.push_back(bad_sum ? (x ^ 8'h01) : x);
`else
    if (bad_sum) stream = stream;
`endif
  endtask

  task automatic build_random(input int n, input bit bad_sum);
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    for (int k = 0; k < 4*n; k++) stream.push_back(8'($urandom_range(0, 255)));
    add_tail(bad_sum);
  endtask

  // mode 0: valid held high; 1: valid low every other cycle; 2: random gaps.
  task automatic send_bytes(input string tag, input int mode);
    int i   = 0;
    int cyc = 0;
    bit drive;
    while (i < stream.size() && cyc < 40*stream.size() + 40) begin
      @(negedge clk);
      cyc++;
      drive = (mode == 0) || (mode == 1 && cyc % 2 == 0) ||
              (mode == 2 && $urandom_range(0, 2) != 0);
      byte_valid = drive;
      byte_data  = drive ? stream[i] : 8'($urandom_range(0, 255));
      if (drive && byte_ready) i++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    check({tag, ":bytes_sent"}, i, stream.size());
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_session(input string tag, input int mode);
    wr_t got;
    wr_q.delete();
    ready_in_write = 0;
    model_stream(stream);
    pulse_start();
    check({tag, ":done_cleared"}, done, 1'b0);
    check({tag, ":busy_on"}, busy, 1'b1);
    send_bytes(tag, mode);
    for (int c = 0; c < 50 && !done; c++) @(negedge clk);
    check({tag, ":done"}, done, 1'b1);
    repeat (3) @(negedge clk);
    check({tag, ":done_held"}, done, 1'b1);
    check({tag, ":busy_off"}, busy, 1'b0);
    check({tag, ":err"}, err, exp_err);
    check({tag, ":word_cnt"}, word_cnt, exp_q.size());
    check({tag, ":n_writes"}, wr_q.size(), exp_q.size());
    check({tag, ":ready_in_write"}, ready_in_write, 0);
    foreach (exp_q[i]) begin
      got = 'x;
      if (i < wr_q.size()) got = wr_q[i];
      check($sformatf("%s:addr%0d", tag, i), got.addr, exp_q[i].addr);
      check($sformatf("%s:data%0d", tag, i), got.data, exp_q[i].data);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst:byte_ready", byte_ready, 1'b0);
    check("rst:data_en", data_en, 1'b0);
    check("rst:input_addr", input_addr, 32'h0);
    check("rst:input_data", input_data, 32'h0);
    check("rst:busy", busy, 1'b0);
    check("rst:done", done, 1'b0);
    check("rst:err", err, 1'b0);
    check("rst:word_cnt", word_cnt, 16'h0);
    rst = 1'b0;
    pulse_start();
    check("start:busy", busy, 1'b1);
    check("start:byte_ready", byte_ready, 1'b1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("rst2:busy", busy, 1'b0);

    // Two-word load, valid held high.
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    add_tail(1'b0);
    run_session("two_word", 0);
    check("two_word:w0", (wr_q.size() > 0) ? wr_q[0].data : 'x, 32'h1234_5678);
    check("two_word:w1", (wr_q.size() > 1) ? wr_q[1].data : 'x, 32'hDEAD_BEEF);
    check("two_word:a1", (wr_q.size() > 1) ? wr_q[1].addr : 'x, 32'h4);

    // Bubbly upstream.
    run_session("bubbly", 1);

    // Zero count.
    stream = '{8'h00, 8'h00};
    add_tail(1'b0);
    run_session("zero", 0);

    // Count overflow (257).
    stream = '{8'h01, 8'h01};
    run_session("overflow", 0);
    check("overflow:err_set", err, 1'b1);

    // Reset after two bytes of the first word.
    wr_q.delete();
    stream = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    pulse_start();
    send_bytes("midrst", 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst:no_write", wr_q.size(), 0);
    check("midrst:busy", busy, 1'b0);
    check("midrst:done", done, 1'b0);
    stream = '{8'h01, 8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h8B};
    add_tail(1'b0);
    run_session("after_rst", 0);
    check("after_rst:addr", (wr_q.size() > 0) ? wr_q[0].addr : 'x, BASE);

`ifdef DMEM_LOADER_CHECKSUM_EN
    stream = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_session("csum_ok", 0);
    check("csum_ok:err", err, 1'b0);
    stream = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    run_session("csum_bad", 0);
    check("csum_bad:err", err, 1'b1);
    check("csum_bad:data", (wr_q.size() > 0) ? wr_q[0].data : 'x, 32'h4433_2211);
`endif

    // Randomized sessions.
    for (int r = 0; r < 12; r++) begin
      build_random($urandom_range(0, 5), $urandom_range(0, 3) == 0);
      run_session($sformatf("rand%0d", r), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
